// File: rtl/truth_table_sweeper.sv
`timescale 1ns/1ps
// Exhaustive truth-table sweeper: walks every input vector, holds it,
// checks the DUT response against a packed table and reports a verdict.
module truth_table_sweeper #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int HOLD  = 20,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] resp,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_valid
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [N_IN-1:0] stim_n, ffv_n;
    logic [N_IN:0]   err_n;
    logic            busy_n, done_n, pass_n, ffok_n;
    logic [N_OUT-1:0] exp_resp;
    logic            hit, mism;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            stim             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            stim             <= stim_n;
            busy             <= busy_n;
            done             <= done_n;
            pass             <= pass_n;
            err_count        <= err_n;
            first_fail_vec   <= ffv_n;
            first_fail_valid <= ffok_n;
        end
    end

    always_comb begin
        exp_resp = EXPECTED[int'(stim)*N_OUT +: N_OUT];
        // Case inequality so X/Z on the response is always a failure
        mism     = (resp !== exp_resp);
        hit      = (cnt == CW'(HOLD - 1));
        state_n  = state;
        cnt_n    = cnt;
        stim_n   = stim;
        busy_n   = busy;
        done_n   = done;
        pass_n   = pass;
        err_n    = err_count;
        ffv_n    = first_fail_vec;
        ffok_n   = first_fail_valid;
        if (abort) begin
            // Results are kept for post-mortem; the pending compare is dropped
            state_n = IDLE;
            cnt_n   = '0;
            stim_n  = '0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            pass_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_n = SWEEP;
                        cnt_n   = '0;
                        stim_n  = '0;
                        busy_n  = 1'b1;
                        done_n  = 1'b0;
                        pass_n  = 1'b0;
                        err_n   = '0;
                        ffv_n   = '0;
                        ffok_n  = 1'b0;
                    end
                end
                SWEEP: begin
                    if (hit) begin
                        cnt_n = '0;
                        if (mism) begin
                            err_n = err_count + 1'b1;
                            if (!first_fail_valid) begin
                                ffv_n  = stim;
                                ffok_n = 1'b1;
                            end
                        end
                        if (stim == '1) begin
                            state_n = DONE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            pass_n  = (err_n == '0);
                        end else begin
                            stim_n = stim + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
`timescale 1ns/1ps
// Bench for truth_table_sweeper: golden f1=a&b|c, f2=a^d on a 4-input block,
// random fault sets and abort points checked against a vector-level model.
module tb_truth_table_sweeper;

    localparam int N_IN = 4;
    localparam int N_OUT = 2;
    localparam int HOLD = 4;
    localparam int NV = 16;

    function automatic logic [1:0] golden(input logic [3:0] v);
        logic a, b, c, d;
        a = v[0]; b = v[1]; c = v[2]; d = v[3];
        return {a ^ d, (a & b) | c};
    endfunction

    function automatic logic [31:0] build_tbl();
        logic [31:0] t;
        t = '0;
        for (int v = 0; v < 16; v++) t[v*2 +: 2] = golden(4'(v));
        return t;
    endfunction

    localparam logic [31:0] EXP = build_tbl();

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [1:0] resp;
    logic [3:0] stim;
    logic busy, done, pass;
    logic [4:0] err;
    logic [3:0] ffv;
    logic ffok;

    logic start1 = 1'b0;
    logic abort1 = 1'b0;
    logic [1:0] resp1;
    logic [3:0] stim1;
    logic busy1, done1, pass1;
    logic [4:0] err1;
    logic [3:0] ffv1;
    logic ffok1;

    int mode = 0;
    logic [15:0] fmask = '0;
    logic [1:0] flip = 2'b01;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .HOLD(HOLD),
                          .EXPECTED(EXP)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .resp(resp), .stim(stim), .busy(busy), .done(done), .pass(pass),
        .err_count(err), .first_fail_vec(ffv), .first_fail_valid(ffok)
    );

    truth_table_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .HOLD(1),
                          .EXPECTED(EXP)) u_h1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .resp(resp1), .stim(stim1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_vec(ffv1), .first_fail_valid(ffok1)
    );

    // Lab block under test, with optional fault injection
    always_comb begin
        case (mode)
            1:       resp = 2'bxx;
            2:       resp = ~golden(stim);
            default: resp = golden(stim) ^ (fmask[stim] ? flip : 2'b00);
        endcase
    end

    always_comb resp1 = golden(stim1);

    function automatic logic [1:0] drv(input int v);
        case (mode)
            1:       return 2'bxx;
            2:       return ~golden(4'(v));
            default: return golden(4'(v)) ^ (fmask[v] ? flip : 2'b00);
        endcase
    endfunction

    // Mismatches whose compare edge lands strictly before edge lim
    function automatic int m_errs(input int lim);
        int n;
        n = 0;
        for (int v = 0; v < NV; v++)
            if ((v + 1) * HOLD < lim && drv(v) !== golden(4'(v))) n++;
        return n;
    endfunction

    function automatic int m_first(input int lim);
        for (int v = 0; v < NV; v++)
            if ((v + 1) * HOLD < lim && drv(v) !== golden(4'(v))) return v;
        return -1;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] o;
        #2;
        o = {stim, busy, done, pass, err, ffv, ffok};
        checks++;
        if (o !== 16'h0) $display("FAIL reset_outs got %h want 0000", o);
        else passes++;
        o = {stim1, busy1, done1, pass1, err1, ffv1, ffok1};
        checks++;
        if (o !== 16'h0) $display("FAIL reset_outs_h1 got %h want 0000", o);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy, done);
        else passes++;
    endtask

    task automatic test_clean_sweep();
        mode = 0;
        fmask = '0;
        pulse_start();
        checks++;
        if (stim !== 4'd0 || busy !== 1'b1)
            $display("FAIL start_edge stim=%0d busy=%b want 0 1", stim, busy);
        else passes++;
        for (int v = 1; v < NV; v++) begin
            repeat (HOLD) @(posedge clk);
            #1;
            checks++;
            if (stim !== 4'(v) || busy !== 1'b1)
                $display("FAIL step_%0d stim=%0d busy=%b want %0d 1", v, stim, busy, v);
            else passes++;
        end
        repeat (HOLD - 1) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL cycle63 done=%b busy=%b want 0 1", done, busy);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy, pass, err, ffok, stim} !== {3'b101, 5'd0, 1'b0, 4'd15})
            $display("FAIL cycle64 d=%b b=%b p=%b e=%0d fv=%b s=%0d want 1 0 1 0 0 15",
                     done, busy, pass, err, ffok, stim);
        else passes++;
    endtask

    task automatic run_and_check(input string tag);
        int cyc, ee, ef;
        pulse_start();
        checks++;
        if (err !== 5'd0 || done !== 1'b0 || busy !== 1'b1 || ffok !== 1'b0)
            $display("FAIL %s_clear e=%0d d=%b b=%b fv=%b want 0 0 1 0",
                     tag, err, done, busy, ffok);
        else passes++;
        wait_done(cyc);
        ee = m_errs(1 << 30);
        ef = m_first(1 << 30);
        checks++;
        if (cyc !== NV * HOLD) $display("FAIL %s_latency got %0d want %0d", tag, cyc, NV * HOLD);
        else passes++;
        checks++;
        if (err !== 5'(ee)) $display("FAIL %s_err got %0d want %0d", tag, err, ee);
        else passes++;
        checks++;
        if (ffok !== (ef >= 0) || ffv !== ((ef >= 0) ? 4'(ef) : 4'd0))
            $display("FAIL %s_first got %b/%0d want %b/%0d", tag, ffok, ffv, ef >= 0, ef);
        else passes++;
        checks++;
        if (pass !== (ee == 0)) $display("FAIL %s_pass got %b want %b", tag, pass, ee == 0);
        else passes++;
    endtask

    task automatic test_faults();
        mode = 0;
        fmask = 16'h1200;
        flip = 2'($urandom_range(1, 3));
        run_and_check("vec9_12");
        mode = 1;
        run_and_check("xresp");
        mode = 2;
        run_and_check("allwrong");
        for (int i = 0; i < 4; i++) begin
            mode = 0;
            fmask = 16'($urandom);
            if (i == 0) fmask = '0;
            flip = 2'($urandom_range(1, 3));
            run_and_check("rand");
        end
    endtask

    task automatic test_abort(input int a);
        int cyc, ee;
        pulse_start();
        repeat (a - 1) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        ee = m_errs(a);
        checks++;
        if ({stim, busy, done, pass} !== 7'd0)
            $display("FAIL abort_%0d s=%0d b=%b d=%b p=%b want 0 0 0 0",
                     a, stim, busy, done, pass);
        else passes++;
        checks++;
        if (err !== 5'(ee)) $display("FAIL abort_%0d_err got %0d want %0d", a, err, ee);
        else passes++;
        mode = 0;
        fmask = '0;
        pulse_start();
        checks++;
        if (err !== 5'd0) $display("FAIL abort_restart_clear got %0d want 0", err);
        else passes++;
        wait_done(cyc);
        checks++;
        if (cyc !== 64 || pass !== 1'b1)
            $display("FAIL abort_restart cyc=%0d pass=%b want 64 1", cyc, pass);
        else passes++;
    endtask

    task automatic test_abort_all();
        mode = 0;
        fmask = 16'h0002;
        flip = 2'b10;
        test_abort(10);
        for (int i = 0; i < 3; i++) begin
            fmask = 16'($urandom);
            flip = 2'($urandom_range(1, 3));
            test_abort($urandom_range(1, 63));
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        mode = 0;
        fmask = 16'h0010;
        flip = 2'b01;
        pulse_start();
        repeat (29) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stim, busy, done, pass, err, ffv, ffok} !== 16'h0)
            $display("FAIL async_reset got %h want 0000",
                     {stim, busy, done, pass, err, ffv, ffok});
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        fmask = '0;
        pulse_start();
        wait_done(cyc);
        checks++;
        if (cyc !== 64 || pass !== 1'b1 || err !== 5'd0)
            $display("FAIL post_reset_sweep cyc=%0d p=%b e=%0d want 64 1 0", cyc, pass, err);
        else passes++;
    endtask

    task automatic test_start_ignored();
        int cyc;
        mode = 0;
        fmask = '0;
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (stim !== 4'd5) $display("FAIL restart_at5 stim=%0d want 5", stim);
        else passes++;
        pulse_start();
        wait_done(cyc);
        checks++;
        if (cyc + 21 !== 64 || pass !== 1'b1)
            $display("FAIL start_ignored done_at=%0d want 64", cyc + 21);
        else passes++;
    endtask

    task automatic test_hold1();
        int cyc;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done1) begin
                cyc = i;
                break;
            end
        end
        checks++;
        if (cyc !== 16 || pass1 !== 1'b1 || err1 !== 5'd0)
            $display("FAIL hold1 cyc=%0d p=%b e=%0d want 16 1 0", cyc, pass1, err1);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_faults();
        test_abort_all();
        test_async_reset();
        test_start_ignored();
        test_hold1();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
